// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with default-master parking, locked-transfer
// holding and a per-master tenure cap. All state advances only on hready.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_TENURE     = 16
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [((NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1)-1:0] hmaster,
    output logic                   hmastlock
);

    localparam int MW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
    localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;

    state_t                   state, state_nxt;
    logic [MW-1:0]            g_idx, g_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic [NUM_MASTERS-1:0]   grant_nxt;
    logic                     others_req;
    logic                     tenure_ok;
    logic                     rr_found;
    logic [MW-1:0]            rr_idx;
    logic [MW-1:0]            cand;

    always_comb begin
        others_req = |(hbusreq & ~hgrant);
        tenure_ok  = (MAX_TENURE == 0) || (int'(cnt) < MAX_TENURE - 1) || !others_req;
    end

    // Search starts just after the current owner so every requester gets its turn.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = g_idx;
        cand     = '0;
        for (int k = 1; k < NUM_MASTERS; k++) begin
            cand = MW'((int'(g_idx) + k) % NUM_MASTERS);
            if (!rr_found && hbusreq[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g_idx;
        cnt_nxt   = cnt;
        if (hbusreq[g_idx] && hlock[g_idx]) begin
            state_nxt = LOCK;
        end else if (hbusreq[g_idx] && tenure_ok) begin
            state_nxt = OWN;
            cnt_nxt   = (cnt == '1) ? cnt : cnt + CW'(1);
        end else if (rr_found) begin
            state_nxt = OWN;
            g_nxt     = rr_idx;
            cnt_nxt   = '0;
        end else begin
            state_nxt = PARK;
            g_nxt     = MW'(DEFAULT_MASTER);
            cnt_nxt   = '0;
        end
        grant_nxt        = '0;
        grant_nxt[g_nxt] = 1'b1;
    end

    // hmaster/hmastlock sample the grant in force before the edge: address phase lags grant.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= PARK;
            g_idx     <= MW'(DEFAULT_MASTER);
            cnt       <= '0;
            hgrant    <= DEFAULT_GRANT;
            hmaster   <= MW'(DEFAULT_MASTER);
            hmastlock <= 1'b0;
        end else if (hready) begin
            state     <= state_nxt;
            g_idx     <= g_nxt;
            cnt       <= cnt_nxt;
            hgrant    <= grant_nxt;
            hmaster   <= g_idx;
            hmastlock <= hlock[g_idx];
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter (4 masters, park on 0, tenure 4):
// vector table plus hand-written round-robin, lock and reset sequences.
module tb_ahb_arbiter;

    logic       hclk;
    logic       hresetn;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] master;
        logic       ml;
        string      name;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       rdy;
        logic [3:0] grant;
        logic [1:0] master;
        logic       ml;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[25];

    ahb_arbiter #(
        .NUM_MASTERS(4),
        .DEFAULT_MASTER(0),
        .MAX_TENURE(4)
    ) dut (
        .hclk(hclk),
        .hresetn(hresetn),
        .hbusreq(hbusreq),
        .hlock(hlock),
        .hready(hready),
        .hgrant(hgrant),
        .hmaster(hmaster),
        .hmastlock(hmastlock)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = exp_q.pop_front();
            check_val({e.name, " hgrant"}, 32'(hgrant), 32'(e.grant));
            check_val({e.name, " hmaster"}, 32'(hmaster), 32'(e.master));
            check_val({e.name, " hmastlock"}, 32'(hmastlock), 32'(e.ml));
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic apply_stimulus(input logic [3:0] req, input logic [3:0] lock, input logic rdy,
                                  input logic [3:0] eg, input logic [1:0] em, input logic eml,
                                  input string name);
        exp_t e;
        @(negedge hclk);
        hbusreq = req;
        hlock   = lock;
        hready  = rdy;
        e.grant  = eg;
        e.master = em;
        e.ml     = eml;
        e.name   = name;
        exp_q.push_back(e);
        @(posedge hclk);
        #1;
        check_output();
    endtask

    task automatic check_reset_values(input string name);
        check_val({name, " hgrant"}, 32'(hgrant), 32'h1);
        check_val({name, " hmaster"}, 32'(hmaster), 32'h0);
        check_val({name, " hmastlock"}, 32'(hmastlock), 32'h0);
    endtask

    initial begin
        hresetn = 1'b1;
        hbusreq = '0;
        hlock   = '0;
        hready  = 1'b1;

        // idle, single request, wait-state freeze, non-granted hlock, short lock
        vecs[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
        vecs[3]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd0, 1'b0};
        vecs[4]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd2, 1'b0};
        vecs[6]  = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
        vecs[7]  = '{4'b1000, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0};
        vecs[8]  = '{4'b1000, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0};
        vecs[9]  = '{4'b1000, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0};
        vecs[10] = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd0, 1'b0};
        vecs[11] = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0};
        vecs[12] = '{4'b1001, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0};
        vecs[13] = '{4'b1001, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0};
        vecs[14] = '{4'b1001, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0};
        vecs[15] = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0};
        vecs[16] = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0};
        vecs[17] = '{4'b1001, 4'b0000, 1'b1, 4'b0001, 2'd3, 1'b0};
        vecs[18] = '{4'b1001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};
        vecs[19] = '{4'b1001, 4'b1000, 1'b1, 4'b0001, 2'd0, 1'b0};
        vecs[20] = '{4'b1001, 4'b1000, 1'b1, 4'b0001, 2'd0, 1'b0};
        vecs[21] = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 2'd0, 1'b0};
        vecs[22] = '{4'b1001, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1};
        vecs[23] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd3, 1'b0};
        vecs[24] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0};

        #2 hresetn = 1'b0;
        #2 check_reset_values("reset");
        repeat (2) @(posedge hclk);
        #1 check_reset_values("reset held");
        @(negedge hclk);
        hresetn = 1'b1;

        for (int i = 0; i < 7; i++)
            apply_stimulus(4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, "idle");

        for (int i = 0; i < 25; i++)
            apply_stimulus(vecs[i].req, vecs[i].lock, vecs[i].rdy,
                           vecs[i].grant, vecs[i].master, vecs[i].ml, $sformatf("vec%0d", i));

        // All four request: each owner keeps the bus for four qualified edges.
        for (int e = 1; e <= 17; e++) begin
            int gi;
            int mi;
            gi = (e / 4) % 4;
            mi = ((e - 1) / 4) % 4;
            apply_stimulus(4'b1111, 4'b0000, 1'b1, 4'b0001 << gi, 2'(mi), 1'b0,
                           $sformatf("rr%0d", e));
        end
        apply_stimulus(4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, "rr release");

        // Master 1 runs its tenure up, then locks and holds past the cap while master 3 waits.
        apply_stimulus(4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd0, 1'b0, "lk grant");
        for (int e = 0; e < 3; e++)
            apply_stimulus(4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, "lk own");
        for (int e = 0; e < 40; e++)
            apply_stimulus(4'b1010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, $sformatf("lk hold%0d", e));
        apply_stimulus(4'b1010, 4'b0000, 1'b1, 4'b1000, 2'd1, 1'b0, "lk drop");
        apply_stimulus(4'b1010, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, "lk after");

        apply_stimulus(4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd3, 1'b0, "m2 grant");
        apply_stimulus(4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, "m2 locked");
        #3 hresetn = 1'b0;
        #1 check_reset_values("reset midlock");
        @(posedge hclk);
        #1 check_reset_values("reset midlock held");
        @(negedge hclk);
        hbusreq = '0;
        hlock   = '0;
        hresetn = 1'b1;
        for (int i = 0; i < 3; i++)
            apply_stimulus(4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, "post reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter for the AHB interconnect. Shares one AHB bus between up to 8 masters. Produces one-hot registered grants, the address-phase master number `hmaster` that steers the address/data muxes in front of the slave decoder, and `hmastlock`. Adds default-master parking, locked-transfer holding and a tenure cap for fairness.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of requesters, legal range 2..8.
- `DEFAULT_MASTER`, 0: master granted when nobody requests (park), 0..NUM_MASTERS-1.
- `MAX_TENURE`, 16: maximum hready-qualified cycles one unlocked master keeps the grant while others wait; 0 disables preemption.

Ports:
- `hclk`, in, 1: bus clock; all state updates on its rising edge.
- `hresetn`, in, 1: **asynchronous, active-low reset**.
- `hbusreq`, in, NUM_MASTERS: bus request, one bit per master.
- `hlock`, in, NUM_MASTERS: locked-access request, one bit per master.
- `hready`, in, 1: shared transfer-done from the slave mux; qualifies every state update.
- `hgrant`, out, NUM_MASTERS: one-hot grant, registered.
- `hmaster`, out, clog2(NUM_MASTERS) (min 1): master owning the current address phase, registered.
- `hmastlock`, out, 1: current address phase is locked, registered.

## Operation
- `g` is the index of the asserted `hgrant` bit. State machine: PARK (granted without request), OWN (granted to a requester), LOCK (granted with lock held). Tenure counter `cnt` is saturating, width clog2(MAX_TENURE+1).
- All updates below happen only at edges with `hready`=1. With `hready`=0, `hgrant`, `hmaster`, `hmastlock`, the state and `cnt` all hold.
- Grant rule at each qualified edge, first match wins:
  1. `hbusreq[g]`=1 and `hlock[g]`=1 -> hold `g`, state LOCK, `cnt` unchanged. Tenure is not applied.
  2. `hbusreq[g]`=1, and at least one of the following holds -> hold `g`, state OWN, `cnt`++ (saturating):
     - MAX_TENURE=0;
     - `cnt` < MAX_TENURE-1;
     - no other `hbusreq` bit set.
  3. Any other requester -> grant the first requesting index found from g+1 upward, wrapping modulo NUM_MASTERS and excluding `g`. State OWN, `cnt`=0.
  4. No request at all -> grant DEFAULT_MASTER, state PARK, `cnt`=0.
- A tenure-expired master (rule 2 fails) loses the grant even if still requesting and re-queues behind the others. If it is the only requester it keeps the grant.
- Leaving LOCK happens only when `hlock[g]` or `hbusreq[g]` drops; the rules then apply normally.
- `hlock` of a non-granted master has no effect until that master is granted.
- At each qualified edge, `hmaster` <= `g` and `hmastlock` <= `hlock[g]`. Both use the grant in effect before the edge, so `hmaster` tracks `hgrant` one address phase late.
- Exactly one `hgrant` bit is set at all times, including in reset.

## Timing
- Reset (async assert, sync release) sets:
  - `hgrant` = one-hot DEFAULT_MASTER;
  - `hmaster` = DEFAULT_MASTER;
  - `hmastlock` = 0;
  - state PARK, `cnt` = 0.
- Request latency from PARK with `hready`=1 throughout:
  - `hbusreq[i]` rises before edge N;
  - `hgrant[i]` goes high after edge N;
  - `hmaster`=i after edge N+1.
- Handover latency: the owner drops `hbusreq` before edge N; the new grant is visible after edge N and the new `hmaster` after edge N+1.
- A stalled `hready` stretches every latency above by the number of low cycles. Grants never change mid-wait-state.
- Simultaneous requests are resolved by round-robin order from g+1. No master waits more than (NUM_MASTERS-1) tenures.
- Reset asserted mid-transfer or mid-lock forces the reset values immediately. There is no recovery of the prior grant.

## Test plan
- Reset/idle: hold `hresetn`=0, then release with no requests for 10 cycles -> `hgrant`=4'b0001, `hmaster`=0, `hmastlock`=0 throughout.
- Single request: `hbusreq`=4'b0100 at edge N, `hready`=1 -> `hgrant`=4'b0100 after N, `hmaster`=2 after N+1. Drop the request -> `hgrant`=4'b0001 next edge.
- Round-robin: `hbusreq`=4'b1111 with MAX_TENURE=4 -> grants cycle 1,2,3,0 with 4 cycles each, `hmaster` trailing by 1 cycle.
- Lock: master 1 requests with `hlock[1]`=1 while master 3 requests, for 40 cycles -> `hgrant` stays 4'b0010 past the tenure limit and `hmastlock`=1. Drop `hlock[1]` -> grant moves to master 3 on the next edge.
- Wait states: during a grant transition hold `hready`=0 for 3 cycles -> `hgrant`, `hmaster` and `cnt` frozen; the transition completes on the first edge with `hready`=1.
- Reset mid-lock: assert `hresetn`=0 mid-cycle while master 2 is locked -> outputs return to the reset values before the next clock edge.
